// File: rtl/nes_transmitter_if.sv
// Console-side bundle for the NES controller transmitter: strobes and buttons in,
// serial data and frame status out.
interface nes_transmitter_if;
  logic       latch;
  logic       pulse;
  logic [7:0] buttons;
  logic       data;
  logic       busy;
  logic       frame_done;
  logic [2:0] bit_index;

  modport master (
    output latch, pulse, buttons,
    input  data, busy, frame_done, bit_index
  );

  modport slave (
    input  latch, pulse, buttons,
    output data, busy, frame_done, bit_index
  );
endinterface

// File: rtl/nes_transmitter.sv
// NES controller emulator: captures active-low buttons on latch and serialises them
// MSB-first (A first) on each console clock rise.
module nes_transmitter (
  input logic            clk,
  input logic            reset,
  nes_transmitter_if.slave nes_io
);

  typedef enum logic [1:0] {StIdle, StLoad, StShift, StDone} state_e;

  state_e     state_q, state_d;
  logic [2:0] latch_sync_q, pulse_sync_q;  // [0]=sync1, [1]=sync2, [2]=edge-detect flop
  logic [7:0] btn_s1_q, btn_s2_q;
  logic [7:0] shift_q, shift_d;
  logic       data_q, data_d;
  logic       busy_q, busy_d;
  logic       frame_done_q, frame_done_d;
  logic [2:0] bit_index_q, bit_index_d;

  logic latch_hi, latch_fall, pulse_rise;

  assign latch_hi   = latch_sync_q[1];
  assign latch_fall = ~latch_sync_q[1] & latch_sync_q[2];
  assign pulse_rise = pulse_sync_q[1] & ~pulse_sync_q[2];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      latch_sync_q <= 3'b000;
      pulse_sync_q <= 3'b000;
      btn_s1_q     <= 8'h00;
      btn_s2_q     <= 8'h00;
    end else begin
      latch_sync_q <= {latch_sync_q[1:0], nes_io.latch};
      pulse_sync_q <= {pulse_sync_q[1:0], nes_io.pulse};
      btn_s1_q     <= nes_io.buttons;
      btn_s2_q     <= btn_s1_q;
    end
  end

  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    data_d       = data_q;
    bit_index_d  = bit_index_q;
    frame_done_d = 1'b0;
    // A latch level overrides everything, including a coincident pulse rise.
    if (latch_hi) begin
      state_d     = StLoad;
      shift_d     = btn_s2_q;
      data_d      = btn_s2_q[7];
      bit_index_d = 3'd0;
    end else begin
      unique case (state_q)
        StIdle: begin
          data_d      = 1'b1;
          bit_index_d = 3'd0;
        end
        StLoad: begin
          data_d      = shift_q[7];
          bit_index_d = 3'd0;
          if (latch_fall) state_d = StShift;
        end
        StShift: begin
          if (pulse_rise) begin
            shift_d = {shift_q[6:0], 1'b0};
            if (bit_index_q == 3'd7) begin
              data_d       = 1'b0;
              frame_done_d = 1'b1;
              state_d      = StDone;
            end else begin
              data_d      = shift_q[6];
              bit_index_d = bit_index_q + 3'd1;
            end
          end
        end
        StDone: begin
          data_d      = 1'b0;
          bit_index_d = 3'd7;
        end
        default: begin
          state_d     = StIdle;
          data_d      = 1'b1;
          bit_index_d = 3'd0;
        end
      endcase
    end
    busy_d = (state_d == StLoad) || (state_d == StShift);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      shift_q      <= 8'hFF;
      data_q       <= 1'b1;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      bit_index_q  <= 3'd0;
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      data_q       <= data_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      bit_index_q  <= bit_index_d;
    end
  end

  assign nes_io.data       = data_q;
  assign nes_io.busy       = busy_q;
  assign nes_io.frame_done = frame_done_q;
  assign nes_io.bit_index  = bit_index_q;

endmodule
